bias_sweep_sequencer: RTL and testbench



---
 rtl/bias_sweep_pkg.sv | 29 ++
 rtl/bias_sweep_settle_timer.sv | 35 +++
 rtl/bias_sweep_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bias_sweep_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_sweep_pkg.sv
// bias_sweep_pkg
// Shared types and constants for the bias sweep sequencer:
//   - state_t     : sequencer FSM states
//   - DEF_*       : default parameter values for the sequencer
//   - res_width() : result/accumulator width (ADC_W + AVG_LOG2)
package bias_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        ACCUM  = 3'd4,
        EMIT   = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam int DEF_DAC_W      = 8;
    localparam int DEF_ADC_W      = 12;
    localparam int DEF_SETTLE_CYC = 64;
    localparam int DEF_AVG_LOG2   = 2;

    // The sum of 2^avg_log2 samples of adc_w bits fits in adc_w + avg_log2
    // bits, so the accumulator never overflows.
    function automatic int res_width(input int adc_w, input int avg_log2);
        return adc_w + avg_log2;
    endfunction

endpackage

// File: rtl/bias_sweep_settle_timer.sv
// bias_sweep_settle_timer
// Loadable down-counter used to time the analog settle interval after each
// DAC update.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded into the counter
//   dec       : decrement by one while non-zero
//   expired   : counter is zero
module bias_sweep_settle_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/bias_sweep_sequencer.sv
// bias_sweep_sequencer
// Steps the bias-current DAC through a programmed sweep, waits a settle
// interval after each step, collects 2^AVG_LOG2 ADC samples and emits the
// summed result once per step.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : one-cycle pulse, begins a sweep when idle
//   abort                    : level, ends the sweep at the next clock
//   code_start/step, n_steps : sweep configuration (step/n_steps 0 -> 1)
//   dac_code, dac_en         : bias DAC code and source enable
//   adc_req/adc_ack/adc_data : sample handshake (req held until ack)
//   res_valid/step/value     : one-cycle result strobe with step index and sum
//   busy, done               : not idle / one-cycle end-of-sweep pulse
// Optional build macro BIAS_SWEEP_DELTA_EN: res_value carries the two's-
// complement difference between this step's sum and the previous step's sum
// (step 0 reports its own sum).
module bias_sweep_sequencer
    import bias_sweep_pkg::*;
#(
    parameter int DAC_W      = DEF_DAC_W,
    parameter int ADC_W      = DEF_ADC_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DAC_W-1:0]          code_start,
    input  logic [DAC_W-1:0]          code_step,
    input  logic [DAC_W-1:0]          n_steps,
    output logic [DAC_W-1:0]          dac_code,
    output logic                      dac_en,
    output logic                      adc_req,
    input  logic                      adc_ack,
    input  logic [ADC_W-1:0]          adc_data,
    output logic                      res_valid,
    output logic [DAC_W-1:0]          res_step,
    output logic [ADC_W+AVG_LOG2-1:0] res_value,
    output logic                      busy,
    output logic                      done
);

    localparam int RES_W = res_width(ADC_W, AVG_LOG2);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] N_SAMP      = CNT_W'(1 << AVG_LOG2);

    state_t             state_reg;
    state_t             state_next;
    logic [DAC_W-1:0]   dac_code_reg;
    logic               dac_en_reg;
    logic [DAC_W-1:0]   step_idx_reg;
    logic [DAC_W-1:0]   code_step_reg;
    logic [DAC_W-1:0]   n_steps_reg;
    logic [CNT_W-1:0]   sample_cnt_reg;
    logic [RES_W-1:0]   acc_reg;
    logic [DAC_W-1:0]   res_step_reg;
    logic [RES_W-1:0]   res_value_reg;
    logic               settle_expired;
    logic               last_step;
`ifdef BIAS_SWEEP_DELTA_EN
    logic [RES_W-1:0]   prev_sum_reg;
`endif

    assign last_step = (step_idx_reg == (n_steps_reg - 1'b1));

    bias_sweep_settle_timer #(
        .CNT_W (SET_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg == APPLY),
        .load_val (SETTLE_LOAD),
        .dec      (state_reg == SETTLE),
        .expired  (settle_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = APPLY;
            APPLY:   state_next = SETTLE;
            SETTLE:  if (settle_expired) state_next = SAMPLE;
            SAMPLE:  if (adc_ack) state_next = ACCUM;
            ACCUM:   state_next = (sample_cnt_reg == N_SAMP) ? EMIT : SAMPLE;
            EMIT:    state_next = last_step ? FINISH : APPLY;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides every other transition once a sweep is running.
        // In IDLE a simultaneous start wins; abort then acts one cycle later.
        if (abort && (state_reg != IDLE) && (state_reg != FINISH)) begin
            state_next = FINISH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            dac_code_reg   <= '0;
            dac_en_reg     <= 1'b0;
            step_idx_reg   <= '0;
            code_step_reg  <= '0;
            n_steps_reg    <= '0;
            sample_cnt_reg <= '0;
            acc_reg        <= '0;
            res_step_reg   <= '0;
            res_value_reg  <= '0;
`ifdef BIAS_SWEEP_DELTA_EN
            prev_sum_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        code_step_reg  <= (code_step == '0) ? DAC_W'(1) : code_step;
                        n_steps_reg    <= (n_steps == '0) ? DAC_W'(1) : n_steps;
                        dac_code_reg   <= code_start;
                        step_idx_reg   <= '0;
                        sample_cnt_reg <= '0;
                        acc_reg        <= '0;
                    end
                end
                APPLY: begin
                    if (state_next == SETTLE) dac_en_reg <= 1'b1;
                end
                SAMPLE: begin
                    if (state_next == ACCUM) begin
                        acc_reg        <= acc_reg + RES_W'(adc_data);
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
                EMIT: begin
                    acc_reg        <= '0;
                    sample_cnt_reg <= '0;
                    if (state_next == APPLY) begin
                        step_idx_reg <= step_idx_reg + 1'b1;
                        dac_code_reg <= dac_code_reg + code_step_reg;
                    end
                end
                default: ;
            endcase

            // Result registers are loaded on the way into EMIT so that they
            // line up with the res_valid strobe decoded from EMIT.
            if ((state_reg == ACCUM) && (state_next == EMIT)) begin
                res_step_reg <= step_idx_reg;
`ifdef BIAS_SWEEP_DELTA_EN
                res_value_reg <= (step_idx_reg == '0) ? acc_reg : (acc_reg - prev_sum_reg);
                prev_sum_reg  <= acc_reg;
`else
                res_value_reg <= acc_reg;
`endif
            end

            // Entering FINISH (normal end or abort) switches the bias source
            // off and clears the sweep counters while done is asserted.
            if ((state_next == FINISH) && (state_reg != FINISH)) begin
                dac_en_reg     <= 1'b0;
                dac_code_reg   <= '0;
                step_idx_reg   <= '0;
                sample_cnt_reg <= '0;
                acc_reg        <= '0;
            end
        end
    end

    // adc_req is gated by abort so the request drops in the abort cycle.
    assign adc_req   = (state_reg == SAMPLE) && !abort;
    assign res_valid = (state_reg == EMIT);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FINISH);
    assign dac_code  = dac_code_reg;
    assign dac_en    = dac_en_reg;
    assign res_step  = res_step_reg;
    assign res_value = res_value_reg;

endmodule

// File: tb/tb_bias_sweep_sequencer.sv
module tb_bias_sweep_sequencer;

    localparam int SETTLE_CYC = 64;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  code_start;
    logic [7:0]  code_step;
    logic [7:0]  n_steps;
    logic [7:0]  dac_code;
    logic        dac_en;
    logic        adc_req;
    logic        adc_ack;
    logic [11:0] adc_data;
    logic        res_valid;
    logic [7:0]  res_step;
    logic [13:0] res_value;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int res_val_q[$];
    int res_step_q[$];
    int res_dac_q[$];
    int done_cnt  = 0;
    int ack_total = 0;
    int adc_base  = 100;
    int adc_slope = 0;
    bit stray_req = 0;

    bias_sweep_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .code_start (code_start),
        .code_step  (code_step),
        .n_steps    (n_steps),
        .dac_code   (dac_code),
        .dac_en     (dac_en),
        .adc_req    (adc_req),
        .adc_ack    (adc_ack),
        .adc_data   (adc_data),
        .res_valid  (res_valid),
        .res_step   (res_step),
        .res_value  (res_value),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result / done monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                res_val_q.push_back(int'(res_value));
                res_step_q.push_back(int'(res_step));
                res_dac_q.push_back(int'(dac_code));
                $display("result step=%0d value=%0d dac_code=%0d", res_step, res_value, dac_code);
            end
            if (done) done_cnt++;
        end
    end

    // ADC model: ack two cycles after a request; optional stray ack while idle
    initial begin
        int age;
        age = 0;
        adc_ack  = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_ack) begin
                adc_ack = 1'b0;
            end else if (stray_req && !adc_req) begin
                adc_ack   = 1'b1;
                adc_data  = 12'd999;
                stray_req = 1'b0;
                age = 0;
            end else if (adc_req) begin
                age++;
                if (age >= 2) begin
                    adc_ack  = 1'b1;
                    adc_data = 12'(adc_base + int'(dac_code) * adc_slope);
                    ack_total++;
                    age = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Expected res_value for a step given this and the previous step's sum
    function automatic int exp_res(input int idx, input int sum_cur, input int sum_prev);
`ifdef BIAS_SWEEP_DELTA_EN
        return (idx == 0) ? sum_cur : ((sum_cur - sum_prev) & 16'h3FFF);
`else
        return sum_cur;
`endif
    endfunction

    task automatic start_sweep(input int cs, input int st, input int ns);
        res_val_q.delete();
        res_step_q.delete();
        res_dac_q.delete();
        @(negedge clk);
        code_start = 8'(cs);
        code_step  = 8'(st);
        n_steps    = 8'(ns);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt > base) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        code_start = '0;
        code_step  = '0;
        n_steps    = '0;
        repeat (3) @(negedge clk);
        checks++; if (dac_code !== 8'd0) begin errors++; $display("FAIL reset_dac_code: got %0d expected 0", dac_code); end
        checks++; if (dac_en !== 1'b0) begin errors++; $display("FAIL reset_dac_en: got %0b expected 0", dac_en); end
        checks++; if (adc_req !== 1'b0) begin errors++; $display("FAIL reset_adc_req: got %0b expected 0", adc_req); end
        checks++; if ({res_valid, res_step, res_value} !== 23'd0) begin errors++; $display("FAIL reset_result: got valid=%0b step=%0d value=%0d expected 0", res_valid, res_step, res_value); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got busy=%0b done=%0b expected 0", busy, done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        int base;
        int win;
        bit to;
        bit seen_req;
        base = done_cnt;
        start_sweep(10, 5, 3);
        win = 0;
        seen_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (adc_req) begin
                seen_req = 1'b1;
                break;
            end
            if (dac_en) win++;
            @(negedge clk);
        end
        checks++; if (!seen_req || win < SETTLE_CYC || win > SETTLE_CYC + 1) begin errors++; $display("FAIL basic_settle_window: got %0d cycles (req seen=%0b) expected %0d", win, seen_req, SETTLE_CYC); end
        wait_done(base, to);
        checks++; if (to) begin errors++; $display("FAIL basic_done_timeout: got no done expected done"); end
        checks++; if (res_val_q.size() != 3) begin errors++; $display("FAIL basic_result_count: got %0d expected 3", res_val_q.size()); end
        for (int i = 0; i < 3 && i < res_val_q.size(); i++) begin
            checks++; if (res_val_q[i] != exp_res(i, 400, 400)) begin errors++; $display("FAIL basic_value[%0d]: got %0d expected %0d", i, res_val_q[i], exp_res(i, 400, 400)); end
            checks++; if (res_step_q[i] != i) begin errors++; $display("FAIL basic_step[%0d]: got %0d expected %0d", i, res_step_q[i], i); end
            checks++; if (res_dac_q[i] != 10 + 5 * i) begin errors++; $display("FAIL basic_dac[%0d]: got %0d expected %0d", i, res_dac_q[i], 10 + 5 * i); end
        end
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL basic_done_count: got %0d expected %0d", done_cnt - base, 1); end
        checks++; if ({busy, dac_en, dac_code} !== 10'd0) begin errors++; $display("FAIL basic_idle_after: got busy=%0b dac_en=%0b dac_code=%0d expected 0", busy, dac_en, dac_code); end
        $display("test_basic complete");
    endtask

    task automatic test_wrap();
        int base;
        bit to;
        base = done_cnt;
        start_sweep(250, 10, 2);
        wait_done(base, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_done_timeout: got no done expected done"); end
        checks++; if (res_val_q.size() != 2) begin errors++; $display("FAIL wrap_result_count: got %0d expected 2", res_val_q.size()); end
        if (res_dac_q.size() == 2) begin
            checks++; if (res_dac_q[0] != 250) begin errors++; $display("FAIL wrap_dac0: got %0d expected 250", res_dac_q[0]); end
            checks++; if (res_dac_q[1] != 4) begin errors++; $display("FAIL wrap_dac1: got %0d expected 4", res_dac_q[1]); end
            checks++; if (res_val_q[0] != 400) begin errors++; $display("FAIL wrap_value0: got %0d expected 400", res_val_q[0]); end
        end
        $display("test_wrap complete");
    endtask

    task automatic test_zero_cfg();
        int base;
        bit to;
        base = done_cnt;
        start_sweep(77, 0, 0);
        wait_done(base, to);
        checks++; if (to) begin errors++; $display("FAIL zero_done_timeout: got no done expected done"); end
        checks++; if (res_val_q.size() != 1) begin errors++; $display("FAIL zero_result_count: got %0d expected 1", res_val_q.size()); end
        if (res_val_q.size() == 1) begin
            checks++; if (res_dac_q[0] != 77) begin errors++; $display("FAIL zero_dac: got %0d expected 77", res_dac_q[0]); end
            checks++; if (res_val_q[0] != 400) begin errors++; $display("FAIL zero_value: got %0d expected 400", res_val_q[0]); end
            checks++; if (res_step_q[0] != 0) begin errors++; $display("FAIL zero_step: got %0d expected 0", res_step_q[0]); end
        end
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - base); end
        $display("test_zero_cfg complete");
    endtask

    task automatic test_ignore();
        int base;
        int ack_base;
        bit to;
        bit en_seen;
        base = done_cnt;
        ack_base = ack_total;
        start_sweep(30, 2, 2);
        en_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dac_en) begin
                en_seen = 1'b1;
                break;
            end
        end
        checks++; if (!en_seen) begin errors++; $display("FAIL ignore_dac_en_timeout: got dac_en=0 expected 1"); end
        repeat (5) @(negedge clk);
        stray_req = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(base, to);
        checks++; if (to) begin errors++; $display("FAIL ignore_done_timeout: got no done expected done"); end
        checks++; if (res_val_q.size() != 2) begin errors++; $display("FAIL ignore_result_count: got %0d expected 2", res_val_q.size()); end
        for (int i = 0; i < 2 && i < res_val_q.size(); i++) begin
            checks++; if (res_val_q[i] != exp_res(i, 400, 400)) begin errors++; $display("FAIL ignore_value[%0d]: got %0d expected %0d", i, res_val_q[i], exp_res(i, 400, 400)); end
            checks++; if (res_dac_q[i] != 30 + 2 * i || res_step_q[i] != i) begin errors++; $display("FAIL ignore_dac_step[%0d]: got dac=%0d step=%0d expected dac=%0d step=%0d", i, res_dac_q[i], res_step_q[i], 30 + 2 * i, i); end
        end
        checks++; if (ack_total - ack_base != 8) begin errors++; $display("FAIL ignore_ack_count: got %0d expected 8", ack_total - ack_base); end
        $display("test_ignore complete");
    endtask

    task automatic test_abort();
        int base;
        int ack_base;
        bit found;
        base = done_cnt;
        ack_base = ack_total;
        start_sweep(10, 5, 3);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ack_total >= ack_base + 2 && adc_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_sample: got not reached expected SAMPLE after 2 acks"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %0b expected 1", done); end
        checks++; if ({adc_req, dac_en, res_valid} !== 3'b000) begin errors++; $display("FAIL abort_outputs: got req=%0b en=%0b valid=%0b expected 0", adc_req, dac_en, res_valid); end
        @(negedge clk);
        checks++; if ({busy, done, dac_en} !== 3'b000) begin errors++; $display("FAIL abort_idle: got busy=%0b done=%0b en=%0b expected 0", busy, done, dac_en); end
        repeat (10) @(negedge clk);
        checks++; if (res_val_q.size() != 0) begin errors++; $display("FAIL abort_no_result: got %0d results expected 0", res_val_q.size()); end
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (ack_total != ack_base + 2) begin errors++; $display("FAIL abort_ack_count: got %0d expected 2", ack_total - ack_base); end
        $display("test_abort complete");
    endtask

    task automatic test_mid_reset();
        int base;
        bit en_seen;
        base = done_cnt;
        start_sweep(40, 1, 2);
        en_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dac_en) begin
                en_seen = 1'b1;
                break;
            end
        end
        checks++; if (!en_seen) begin errors++; $display("FAIL midrst_dac_en_timeout: got dac_en=0 expected 1"); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({dac_en, busy, done} !== 3'b000) begin errors++; $display("FAIL midrst_async: got en=%0b busy=%0b done=%0b expected 0", dac_en, busy, done); end
        checks++; if (dac_code !== 8'd0) begin errors++; $display("FAIL midrst_dac_code: got %0d expected 0", dac_code); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done_cnt != base || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got done pulses=%0d busy=%0b expected 0", done_cnt - base, busy); end
        $display("test_mid_reset complete");
    endtask

`ifdef BIAS_SWEEP_DELTA_EN
    task automatic test_delta();
        int base;
        bit to;
        base = done_cnt;
        adc_base  = 100;
        adc_slope = 20;
        start_sweep(0, 1, 2);
        wait_done(base, to);
        adc_slope = 0;
        checks++; if (to) begin errors++; $display("FAIL delta_done_timeout: got no done expected done"); end
        checks++; if (res_val_q.size() != 2) begin errors++; $display("FAIL delta_result_count: got %0d expected 2", res_val_q.size()); end
        if (res_val_q.size() == 2) begin
            checks++; if (res_val_q[0] != 400) begin errors++; $display("FAIL delta_value0: got %0d expected 400", res_val_q[0]); end
            checks++; if (res_val_q[1] != 80) begin errors++; $display("FAIL delta_value1: got %0d expected 80", res_val_q[1]); end
        end
        $display("test_delta complete");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_cfg();
        test_ignore();
        test_abort();
        test_mid_reset();
`ifdef BIAS_SWEEP_DELTA_EN
        test_delta();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
